// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard key tracker: parser states, prefix bytes,
// key indices and the scan-code to key-index table.
package kb_pkg;

    localparam int NKEYS = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXT    = 2'd1,
        ST_BRK    = 2'd2,
        ST_EXTBRK = 2'd3
    } kb_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_BAT   = 8'hAA;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_SPACE = 4'd4;
    localparam logic [3:0] KEY_ENTER = 4'd5;
    localparam logic [3:0] KEY_UP    = 4'd6;
    localparam logic [3:0] KEY_LEFT  = 4'd7;
    localparam logic [3:0] KEY_DOWN  = 4'd8;
    localparam logic [3:0] KEY_RIGHT = 4'd9;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } kb_map_t;

    // Base and extended code spaces overlap, so the ext flag is part of the key.
    function automatic kb_map_t kb_lookup(input logic ext, input logic [7:0] code);
        kb_map_t m;
        m.hit = 1'b1;
        m.idx = 4'd0;
        case ({ext, code})
            {1'b0, 8'h1D}: m.idx = KEY_W;
            {1'b0, 8'h1C}: m.idx = KEY_A;
            {1'b0, 8'h1B}: m.idx = KEY_S;
            {1'b0, 8'h23}: m.idx = KEY_D;
            {1'b0, 8'h29}: m.idx = KEY_SPACE;
            {1'b0, 8'h5A}: m.idx = KEY_ENTER;
            {1'b1, 8'h75}: m.idx = KEY_UP;
            {1'b1, 8'h6B}: m.idx = KEY_LEFT;
            {1'b1, 8'h72}: m.idx = KEY_DOWN;
            {1'b1, 8'h74}: m.idx = KEY_RIGHT;
            default: begin
                m.hit = 1'b0;
                m.idx = 4'd0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/kb_code_map.sv
// Combinational scan-code lookup: {ext, byte} -> {hit, key index}.
module kb_code_map
    import kb_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] idx
);

    kb_map_t map_s;

    // Table lookup through the shared package function
    always_comb begin
        map_s = kb_lookup(ext, code);
        hit   = map_s.hit;
        idx   = map_s.idx;
    end

endmodule

// File: rtl/kb_key_tracker.sv
// PS/2 scan-code parser: turns make/break/extended byte sequences into a held-key
// bitmap with one-cycle change events and a sync-error pulse.
module kb_key_tracker
    import kb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_500_000
)
(
    input  logic             CLK,
    input  logic             ARST,
    input  logic [7:0]       KBCODE,
    input  logic             KBSTROBE,
    output logic [NKEYS-1:0] KEYS,
    output logic             EVT_VALID,
    output logic [3:0]       EVT_KEY,
    output logic             EVT_MAKE,
    output logic             SYNC_ERR
);

    localparam logic [21:0] TMO_LAST = 22'(TIMEOUT_CYC - 1);
    localparam logic [21:0] TMO_MAX  = 22'h3F_FFFF;

    kb_state_e        state_q, state_d;
    logic             strb_q, strb_d;
    logic [21:0]      tmo_q, tmo_d;
    logic [NKEYS-1:0] keys_q, keys_d;
    logic             evt_valid_q, evt_valid_d;
    logic [3:0]       evt_key_q, evt_key_d;
    logic             evt_make_q, evt_make_d;
    logic             sync_err_q, sync_err_d;

    logic             accept_s, expire_s, use_ext_s;
    logic             map_hit_s, make_s, brk_s;
    logic [3:0]       map_idx_s;

    assign use_ext_s = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

    kb_code_map u_map (
        .ext  (use_ext_s),
        .code (KBCODE),
        .hit  (map_hit_s),
        .idx  (map_idx_s)
    );

    // Next-state: byte parsing, bitmap update, event generation and prefix timeout
    always_comb begin
        strb_d      = KBSTROBE;
        accept_s    = KBSTROBE & ~strb_q;
        expire_s    = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);
        state_d     = state_q;
        tmo_d       = tmo_q;
        keys_d      = keys_q;
        evt_valid_d = 1'b0;
        evt_key_d   = evt_key_q;
        evt_make_d  = evt_make_q;
        sync_err_d  = 1'b0;
        make_s      = 1'b0;
        brk_s       = 1'b0;

        if (accept_s) begin
            tmo_d = 22'd0;
            case (state_q)
                ST_IDLE: begin
                    case (KBCODE)
                        SC_EXT:   state_d = ST_EXT;
                        SC_BRK:   state_d = ST_BRK;
                        SC_BAT:   keys_d  = {NKEYS{1'b0}};
                        SC_PAUSE: state_d = ST_IDLE;
                        default:  make_s  = map_hit_s;
                    endcase
                end
                ST_EXT: begin
                    case (KBCODE)
                        SC_BRK: state_d = ST_EXTBRK;
                        SC_EXT: state_d = ST_EXT;
                        default: begin
                            state_d    = ST_IDLE;
                            make_s     = map_hit_s;
                            sync_err_d = ~map_hit_s;
                        end
                    endcase
                end
                ST_BRK: begin
                    // F0 E0 is tolerated as an alternative prefix ordering
                    case (KBCODE)
                        SC_EXT: state_d = ST_EXTBRK;
                        default: begin
                            state_d = ST_IDLE;
                            brk_s   = map_hit_s;
                        end
                    endcase
                end
                ST_EXTBRK: begin
                    state_d    = ST_IDLE;
                    brk_s      = map_hit_s;
                    sync_err_d = ~map_hit_s;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (expire_s) begin
            state_d    = ST_IDLE;
            sync_err_d = 1'b1;
        end else if ((state_q != ST_IDLE) && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + 22'd1;
        end else begin
            tmo_d = tmo_q;
        end

        // Repeats of held keys and releases of unheld keys change nothing
        if (make_s && !keys_q[map_idx_s]) begin
            keys_d[map_idx_s] = 1'b1;
            evt_valid_d       = 1'b1;
            evt_key_d         = map_idx_s;
            evt_make_d        = 1'b1;
        end else if (brk_s && keys_q[map_idx_s]) begin
            keys_d[map_idx_s] = 1'b0;
            evt_valid_d       = 1'b1;
            evt_key_d         = map_idx_s;
            evt_make_d        = 1'b0;
        end else begin
            evt_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state_q     <= ST_IDLE;
            strb_q      <= 1'b0;
            tmo_q       <= 22'd0;
            keys_q      <= {NKEYS{1'b0}};
            evt_valid_q <= 1'b0;
            evt_key_q   <= 4'd0;
            evt_make_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            strb_q      <= strb_d;
            tmo_q       <= tmo_d;
            keys_q      <= keys_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_make_q  <= evt_make_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign KEYS      = keys_q;
    assign EVT_VALID = evt_valid_q;
    assign EVT_KEY   = evt_key_q;
    assign EVT_MAKE  = evt_make_q;
    assign SYNC_ERR  = sync_err_q;

endmodule
